// File: rtl/mult_acc_stage_if.sv
// Handshake bundle between the multiplier output, the accumulate stage and its consumer.
interface mult_acc_stage_if #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [WIDTH1+WIDTH2-1:0] prod;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_data;
  logic                     out_ovf;
  logic [CNT_W-1:0]         out_cnt;

  // master drives products and accepts results; slave is the accumulate stage
  modport master (
    output in_valid, in_last, prod, clear, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_cnt
  );

  modport slave (
    input  in_valid, in_last, prod, clear, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_cnt
  );
endinterface

// File: rtl/mult_acc_stage.sv
// Frame accumulator behind the signed multiplier: sums products per frame and
// presents the total, term count and sticky overflow over valid/ready.
module mult_acc_stage #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int ACC_W  = 24,
  parameter int LEN    = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_acc_stage_if.slave  bus
);
  localparam int PW = WIDTH1 + WIDTH2;

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_beat;
  logic             accept;
  logic             frame_end;

  always_comb begin
    prod_ext  = ACC_W'(signed'(bus.prod[PW-1:0]));
    sum       = acc + prod_ext;
    // same-sign addends whose sum flips sign
    ovf_beat  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    accept    = bus.in_valid && (state == ACC) && !bus.clear;
    frame_end = accept && (bus.in_last || (cnt == CNT_W'(LEN - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (bus.clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (frame_end) begin
            out_data_q  <= sum;
            out_ovf_q   <= ovf | ovf_beat;
            out_cnt_q   <= cnt + 1'b1;
            out_valid_q <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            state       <= HOLD;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            ovf <= ovf | ovf_beat;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed bench for mult_acc_stage: default, 16-bit accumulator and LEN=1 instances.
module tb_mult_acc_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mult_acc_stage_if #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .CNT_W(5)) a ();
  mult_acc_stage_if #(.WIDTH1(8), .WIDTH2(8), .ACC_W(16), .CNT_W(5)) b ();
  mult_acc_stage_if #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .CNT_W(5)) c ();

  mult_acc_stage #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .LEN(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a));
  mult_acc_stage #(.WIDTH1(8), .WIDTH2(8), .ACC_W(16), .LEN(16), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b));
  mult_acc_stage #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .LEN(1), .CNT_W(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic beat_a(input int p, input logic l);
    @(negedge clk);
    a.in_valid = 1'b1; a.prod = 16'(p); a.in_last = l;
    @(posedge clk); #1;
    a.in_valid = 1'b0; a.in_last = 1'b0;
  endtask

  task automatic beat_b(input int p, input logic l);
    @(negedge clk);
    b.in_valid = 1'b1; b.prod = 16'(p); b.in_last = l;
    @(posedge clk); #1;
    b.in_valid = 1'b0; b.in_last = 1'b0;
  endtask

  task automatic beat_c(input int p, input logic l);
    @(negedge clk);
    c.in_valid = 1'b1; c.prod = 16'(p); c.in_last = l;
    @(posedge clk); #1;
    c.in_valid = 1'b0; c.in_last = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge clk); a.out_ready = 1'b1;
    @(posedge clk); #1; a.out_ready = 1'b0;
  endtask

  task automatic ack_b();
    @(negedge clk); b.out_ready = 1'b1;
    @(posedge clk); #1; b.out_ready = 1'b0;
  endtask

  task automatic ack_c();
    @(negedge clk); c.out_ready = 1'b1;
    @(posedge clk); #1; c.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    a.in_valid = 0; a.in_last = 0; a.prod = '0; a.clear = 0; a.out_ready = 0;
    b.in_valid = 0; b.in_last = 0; b.prod = '0; b.clear = 0; b.out_ready = 0;
    c.in_valid = 0; c.in_last = 0; c.prod = '0; c.clear = 0; c.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a.in_ready, a.out_valid, a.out_ovf} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags: got ready/valid/ovf=%b%b%b required 100", a.in_ready, a.out_valid, a.out_ovf);
    end
    checks++;
    if (a.out_data !== 24'd0 || a.out_cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_data: got data=%0d cnt=%0d required 0/0", a.out_data, a.out_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat_a(3, 0); beat_a(-5, 0); beat_a(100, 0);
    checks++;
    if (a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %b required 0", a.out_valid);
    end
    beat_a(-1, 1);
    checks++;
    if (a.out_valid !== 1'b1 || $signed(a.out_data) !== 97 || a.out_cnt !== 5'd4 || a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got v=%b data=%0d cnt=%0d ovf=%b required 1/97/4/0",
               a.out_valid, $signed(a.out_data), a.out_cnt, a.out_ovf);
    end
    ack_a();
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_handshake: got valid=%b ready=%b required 0/1", a.out_valid, a.in_ready);
    end
  endtask

  task automatic test_len_full();
    for (int i = 0; i < 15; i++) beat_a(-32768, 0);
    checks++;
    if (a.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL len_early_end: got valid=%b required 0 after 15 beats", a.out_valid);
    end
    beat_a(-32768, 0);
    checks++;
    if (a.out_valid !== 1'b1 || $signed(a.out_data) !== -524288 || a.out_cnt !== 5'd16 || a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL len_result: got v=%b data=%0d cnt=%0d ovf=%b required 1/-524288/16/0",
               a.out_valid, $signed(a.out_data), a.out_cnt, a.out_ovf);
    end
    ack_a();
  endtask

  task automatic test_overflow();
    beat_b(20000, 0); beat_b(20000, 1);
    checks++;
    if (b.out_valid !== 1'b1 || $signed(b.out_data) !== -25536 || b.out_ovf !== 1'b1 || b.out_cnt !== 5'd2) begin
      failures++;
      $display("FAIL ovf_result: got v=%b data=%0d ovf=%b cnt=%0d required 1/-25536/1/2",
               b.out_valid, $signed(b.out_data), b.out_ovf, b.out_cnt);
    end
    ack_b();
    beat_b(5, 1);
    checks++;
    if ($signed(b.out_data) !== 5 || b.out_ovf !== 1'b0 || b.out_cnt !== 5'd1) begin
      failures++;
      $display("FAIL ovf_next_frame: got data=%0d ovf=%b cnt=%0d required 5/0/1",
               $signed(b.out_data), b.out_ovf, b.out_cnt);
    end
    ack_b();
  endtask

  task automatic test_backpressure();
    beat_a(1, 0); beat_a(2, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a.in_valid = 1'b1; a.prod = 16'd99; a.in_last = 1'b1; a.clear = (i == 2);
      @(posedge clk); #1;
      checks++;
      if (a.in_ready !== 1'b0 || a.out_valid !== 1'b1 || $signed(a.out_data) !== 3 || a.out_cnt !== 5'd2) begin
        failures++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b data=%0d cnt=%0d required 0/1/3/2",
                 i, a.in_ready, a.out_valid, $signed(a.out_data), a.out_cnt);
      end
    end
    a.in_valid = 1'b0; a.in_last = 1'b0; a.clear = 1'b0;
    ack_a();
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b required 0/1", a.out_valid, a.in_ready);
    end
    beat_a(4, 1);
    checks++;
    if ($signed(a.out_data) !== 4 || a.out_cnt !== 5'd1) begin
      failures++;
      $display("FAIL bp_no_leak: got data=%0d cnt=%0d required 4/1", $signed(a.out_data), a.out_cnt);
    end
    ack_a();
  endtask

  task automatic test_clear();
    beat_a(7, 0); beat_a(9, 0);
    @(negedge clk);
    a.in_valid = 1'b1; a.prod = 16'd50; a.clear = 1'b1;
    @(posedge clk); #1;
    a.in_valid = 1'b0; a.clear = 1'b0;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_state: got valid=%b ready=%b required 0/1", a.out_valid, a.in_ready);
    end
    beat_a(2, 1);
    checks++;
    if ($signed(a.out_data) !== 2 || a.out_cnt !== 5'd1 || a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clear_result: got data=%0d cnt=%0d ovf=%b required 2/1/0",
               $signed(a.out_data), a.out_cnt, a.out_ovf);
    end
    ack_a();
  endtask

  task automatic test_async_reset();
    beat_a(10, 0); beat_a(20, 0);
    @(negedge clk); #1 rst_n = 1'b0; #1;
    checks++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.out_data !== 24'd0 || a.out_cnt !== 5'd0) begin
      failures++;
      $display("FAIL arst_midframe: got ready=%b valid=%b data=%0d cnt=%0d required 1/0/0/0",
               a.in_ready, a.out_valid, a.out_data, a.out_cnt);
    end
    #1 rst_n = 1'b1;
    beat_a(6, 1);
    checks++;
    if ($signed(a.out_data) !== 6 || a.out_cnt !== 5'd1) begin
      failures++;
      $display("FAIL arst_restart: got data=%0d cnt=%0d required 6/1", $signed(a.out_data), a.out_cnt);
    end
    @(negedge clk); #1 rst_n = 1'b0; #1;
    checks++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.out_data !== 24'd0 || a.out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL arst_hold: got ready=%b valid=%b data=%0d ovf=%b required 1/0/0/0",
               a.in_ready, a.out_valid, a.out_data, a.out_ovf);
    end
    #1 rst_n = 1'b1;
    beat_a(1, 1);
    checks++;
    if ($signed(a.out_data) !== 1 || a.out_cnt !== 5'd1 || a.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_after_hold: got data=%0d cnt=%0d valid=%b required 1/1/1",
               $signed(a.out_data), a.out_cnt, a.out_valid);
    end
    ack_a();
  endtask

  task automatic test_len1();
    beat_c(5, 0);
    checks++;
    if (c.out_valid !== 1'b1 || $signed(c.out_data) !== 5 || c.out_cnt !== 5'd1) begin
      failures++;
      $display("FAIL len1_first: got v=%b data=%0d cnt=%0d required 1/5/1",
               c.out_valid, $signed(c.out_data), c.out_cnt);
    end
    ack_c();
    beat_c(-32768, 0);
    checks++;
    if (c.out_valid !== 1'b1 || $signed(c.out_data) !== -32768 || c.out_cnt !== 5'd1) begin
      failures++;
      $display("FAIL len1_minneg: got v=%b data=%0d cnt=%0d required 1/-32768/1",
               c.out_valid, $signed(c.out_data), c.out_cnt);
    end
    ack_c();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_len_full();
    test_overflow();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_len1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
